// File: rtl/bus_dev_port.sv
// rtl/bus_dev_port.sv - bus device endpoint: TX/RX packet queues with destination filter (optional stats: BUS_DEV_PORT_STATS_EN)

// Synchronous FWFT queue; a write into a full queue is taken only alongside a read.
module bus_dev_port_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          rd_eff;
  logic          wr_eff;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_eff  = rd_en && !empty;
  assign wr_eff  = wr_en && (!full || rd_eff);
  assign rd_data = empty ? '0 : mem[rptr];

  // storage array; contents are don't-care until the count covers them
  always_ff @(posedge clk) begin
    if (wr_eff) begin
      mem[wptr] <= wr_data;
    end
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_eff) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_eff) begin
        rptr <= rptr + 1'b1;
      end
      if (wr_eff && !rd_eff) begin
        count <= count + 1'b1;
      end else if (rd_eff && !wr_eff) begin
        count <= count - 1'b1;
      end
    end
  end
endmodule

// Endpoint top: TX queue drained by bus pops, RX queue filled by filtered bus pushes.
module bus_dev_port #(
  parameter int          pckg_sz   = 16,
  parameter int          depth     = 8,
  parameter logic [7:0]  id        = 8'd0,
  parameter logic [7:0]  broadcast = {8{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  input  logic               rx_rd,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_empty,
`ifdef BUS_DEV_PORT_STATS_EN
  output logic [15:0]        tx_cnt,
  output logic [15:0]        rx_cnt,
  output logic [15:0]        drop_cnt,
`endif
  output logic               rx_ovf
);
  logic       tx_empty;
  logic       rx_full;
  logic [7:0] dest;
  logic       rx_acc;
  logic       rx_rd_eff;
  logic       rx_store;
  logic       rx_drop;

  assign pndng     = !tx_empty;
  assign dest      = D_push[pckg_sz-1 -: 8];
  assign rx_acc    = push && ((dest == id) || (dest == broadcast));
  assign rx_rd_eff = rx_rd && !rx_empty;
  assign rx_store  = rx_acc && (!rx_full || rx_rd_eff);
  assign rx_drop   = rx_acc && !rx_store;

  bus_dev_port_fifo #(.W(pckg_sz), .DEPTH(depth)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tx_wr),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (D_pop),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  bus_dev_port_fifo #(.W(pckg_sz), .DEPTH(depth)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rx_acc),
    .wr_data (D_push),
    .rd_en   (rx_rd),
    .rd_data (rx_data),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  // sticky overflow: an accepted packet was lost because the RX queue had no room
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ovf <= 1'b0;
    end else if (rx_drop) begin
      rx_ovf <= 1'b1;
    end
  end

`ifdef BUS_DEV_PORT_STATS_EN
  logic tx_pop_eff;
  assign tx_pop_eff = pop && pndng;

  // saturating event counters for pops, stores and drops
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (tx_pop_eff && (tx_cnt != 16'hFFFF)) begin
        tx_cnt <= tx_cnt + 16'd1;
      end
      if (rx_store && (rx_cnt != 16'hFFFF)) begin
        rx_cnt <= rx_cnt + 16'd1;
      end
      if (rx_drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_bus_dev_port.sv
// tb/tb_bus_dev_port.sv - randomized self-checking bench for bus_dev_port against a queue model
module tb_bus_dev_port;
  localparam int         W     = 16;
  localparam int         DEPTH = 8;
  localparam logic [7:0] ID    = 8'h02;
  localparam logic [7:0] BC    = 8'hFF;

  logic         clk = 1'b0;
  logic         reset;
  logic         pndng;
  logic [W-1:0] D_pop;
  logic         pop;
  logic         push;
  logic [W-1:0] D_push;
  logic         tx_wr;
  logic [W-1:0] tx_data;
  logic         tx_full;
  logic         rx_rd;
  logic [W-1:0] rx_data;
  logic         rx_empty;
  logic         rx_ovf;
`ifdef BUS_DEV_PORT_STATS_EN
  logic [15:0]  tx_cnt;
  logic [15:0]  rx_cnt;
  logic [15:0]  drop_cnt;
  int           m_tx_cnt;
  int           m_rx_cnt;
  int           m_drop_cnt;
`endif

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] txq[$];
  logic [W-1:0] rxq[$];
  logic         m_ovf;

  always #5 clk = ~clk;

  bus_dev_port #(.pckg_sz(W), .depth(DEPTH), .id(ID), .broadcast(BC)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .tx_wr    (tx_wr),
    .tx_data  (tx_data),
    .tx_full  (tx_full),
    .rx_rd    (rx_rd),
    .rx_data  (rx_data),
    .rx_empty (rx_empty),
`ifdef BUS_DEV_PORT_STATS_EN
    .tx_cnt   (tx_cnt),
    .rx_cnt   (rx_cnt),
    .drop_cnt (drop_cnt),
`endif
    .rx_ovf   (rx_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("pndng",    32'(pndng),    32'(txq.size() != 0));
    check("D_pop",    32'(D_pop),    32'(txq.size() != 0 ? txq[0] : 16'h0));
    check("tx_full",  32'(tx_full),  32'(txq.size() == DEPTH));
    check("rx_empty", 32'(rx_empty), 32'(rxq.size() == 0));
    check("rx_data",  32'(rx_data),  32'(rxq.size() != 0 ? rxq[0] : 16'h0));
    check("rx_ovf",   32'(rx_ovf),   32'(m_ovf));
`ifdef BUS_DEV_PORT_STATS_EN
    check("tx_cnt",   32'(tx_cnt),   32'(m_tx_cnt));
    check("rx_cnt",   32'(rx_cnt),   32'(m_rx_cnt));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop_cnt));
`endif
  endtask

  task automatic cycle(input logic r, input logic twr, input logic [W-1:0] td,
                       input logic p, input logic ps, input logic [W-1:0] dp,
                       input logic rrd);
    int  tn;
    int  rn;
    bit  pe;
    bit  re;
    bit  acc;
    @(negedge clk);
    reset = r; tx_wr = twr; tx_data = td; pop = p; push = ps; D_push = dp; rx_rd = rrd;
    @(posedge clk);
    if (r) begin
      txq.delete();
      rxq.delete();
      m_ovf = 1'b0;
`ifdef BUS_DEV_PORT_STATS_EN
      m_tx_cnt = 0; m_rx_cnt = 0; m_drop_cnt = 0;
`endif
    end else begin
      tn  = txq.size();
      rn  = rxq.size();
      pe  = p && (tn > 0);
      if (pe) void'(txq.pop_front());
      if (twr && (tn < DEPTH || pe)) txq.push_back(td);
      acc = ps && (dp[15:8] == ID || dp[15:8] == BC);
      re  = rrd && (rn > 0);
      if (re) void'(rxq.pop_front());
      if (acc && (rn < DEPTH || re)) rxq.push_back(dp);
      if (acc && !(rn < DEPTH || re)) m_ovf = 1'b1;
`ifdef BUS_DEV_PORT_STATS_EN
      if (pe && m_tx_cnt < 65535) m_tx_cnt++;
      if (acc && (rn < DEPTH || re) && m_rx_cnt < 65535) m_rx_cnt++;
      if (acc && !(rn < DEPTH || re) && m_drop_cnt < 65535) m_drop_cnt++;
`endif
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] rd;
    logic [7:0]   dst;
    m_ovf = 1'b0;
`ifdef BUS_DEV_PORT_STATS_EN
    m_tx_cnt = 0; m_rx_cnt = 0; m_drop_cnt = 0;
`endif
    reset = 1'b1; tx_wr = 1'b0; tx_data = '0; pop = 1'b0; push = 1'b0; D_push = '0; rx_rd = 1'b0;
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    check("reset_pndng", 32'(pndng), 32'd0);
    check("reset_rx_empty", 32'(rx_empty), 32'd1);

    // single packet through TX
    cycle(1'b0, 1'b1, 16'h0A5A, 1'b0, 1'b0, 16'h0, 1'b0);
    check("tx_first_dpop", 32'(D_pop), 32'h0A5A);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("tx_popped_pndng", 32'(pndng), 32'd0);
    check("tx_popped_dpop", 32'(D_pop), 32'd0);

    // fill, dropped ninth write, ninth write with pop, drain across wrap
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
    check("tx_full_after_8", 32'(tx_full), 32'd1);
    cycle(1'b0, 1'b1, 16'h0108, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 16'h0109, 1'b1, 1'b0, 16'h0, 1'b0);
    check("tx_full_wr_pop", 32'(tx_full), 32'd1);
    check("tx_head_after_pop", 32'(D_pop), 32'h0101);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);

    // destination filter
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0211, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0311, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'hFF22, 1'b0);
    check("rx_first", 32'(rx_data), 32'h0211);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    check("rx_second", 32'(rx_data), 32'hFF22);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    check("rx_drained", 32'(rx_empty), 32'd1);

    // RX overflow and store-with-read at full
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0200 + 16'(i), 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0299, 1'b0);
    check("rx_ovf_set", 32'(rx_ovf), 32'd1);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0299, 1'b1);
    check("rx_ovf_sticky", 32'(rx_ovf), 32'd1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);

    // pop / read while empty
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1);
    cycle(1'b0, 1'b1, 16'h0777, 1'b0, 1'b0, 16'h0, 1'b0);
    check("tx_after_empty_pop", 32'(D_pop), 32'h0777);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);

    // reset with traffic pending, including pop/push in the reset cycle
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'hFF40 + 16'(i), 1'b0);
    cycle(1'b1, 1'b1, 16'h0555, 1'b1, 1'b1, 16'h0266, 1'b1);
    check("rst_pndng", 32'(pndng), 32'd0);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_rx_ovf", 32'(rx_ovf), 32'd0);

`ifdef BUS_DEV_PORT_STATS_EN
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'h0400 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("stats_tx_cnt_5", 32'(tx_cnt), 32'd5);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    check("stats_tx_cnt_rst", 32'(tx_cnt), 32'd0);
`endif

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(3))
        0: dst = ID;
        1: dst = BC;
        2: dst = 8'h03;
        default: dst = 8'($urandom);
      endcase
      rd = {dst, 8'($urandom)};
      cycle(($urandom_range(99) == 0), 1'($urandom), 16'($urandom),
            ($urandom_range(2) == 0), 1'($urandom), rd, ($urandom_range(2) == 0));
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
